// File: rtl/j11pins_pkg.sv
// Shared definitions for the DCJ11 pin-side initiator: AIO codes, cycle classes,
// FSM states and small decode helpers.
package j11pins_pkg;

   localparam logic [3:0] AIO_READ    = 4'b1100;
   localparam logic [3:0] AIO_IACK    = 4'b1010;
   localparam logic [3:0] AIO_GPREAD  = 4'b1001;
   localparam logic [3:0] AIO_WRWORD  = 4'b0101;
   localparam logic [3:0] AIO_WRBYTE  = 4'b0100;
   localparam logic [3:0] AIO_GPWRITE = 4'b0011;

   typedef enum logic [2:0] {
      NONBUS, READ, IACK, GPREAD, WRWORD, WRBYTE, GPWRITE
   } cls_t;

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

   function automatic cls_t decode_aio(input logic [3:0] aio);
      cls_t c;
      case (aio)
         AIO_READ:    c = READ;
         AIO_IACK:    c = IACK;
         AIO_GPREAD:  c = GPREAD;
         AIO_WRWORD:  c = WRWORD;
         AIO_WRBYTE:  c = WRBYTE;
         AIO_GPWRITE: c = GPWRITE;
         default:     c = NONBUS;
      endcase
      return c;
   endfunction

   function automatic logic is_write(input cls_t c);
      return (c == WRWORD) || (c == WRBYTE) || (c == GPWRITE);
   endfunction

   // Every cycle that expects the CPU to read the DAL back, IACK included.
   function automatic logic is_read(input cls_t c);
      return (c == READ) || (c == IACK) || (c == GPREAD);
   endfunction

   function automatic logic [1:0] wstrb_for(input cls_t c, input logic addr0);
      logic [1:0] s;
      if (c == WRBYTE)
         s = addr0 ? 2'b10 : 2'b01;
      else if (is_write(c))
         s = 2'b11;
      else
         s = 2'b00;
      return s;
   endfunction

endpackage

// File: rtl/j11pins_if.sv
// Internal-bus side of the J11 initiator: one-cycle request out, ack/error/data back.
interface j11pins_if;
   logic        busreq;
   logic        buswr;
   logic        busgp;
   logic        busirq;
   logic [21:0] busaddr;
   logic [15:0] buswdata;
   logic [1:0]  buswstrb;
   logic        busack;
   logic        buserr;
   logic [15:0] busrdata;

   modport master (
      output busreq, buswr, busgp, busirq, busaddr, buswdata, buswstrb,
      input  busack, buserr, busrdata
   );

   modport slave (
      input  busreq, buswr, busgp, busirq, busaddr, buswdata, buswstrb,
      output busack, buserr, busrdata
   );
endinterface

// File: rtl/j11pins_sync.sv
// Flop-chain synchroniser with preset-to-1 reset and fall/rise pulses taken
// from the synchronised level (previous vs current).
module j11sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q,
   output logic fall,
   output logic rise
);
   logic [STAGES-1:0] chain_reg;
   logic [STAGES:0]   taps;
   logic              prev_reg;

   assign taps = {chain_reg, d};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chain_reg <= '1;
         prev_reg  <= 1'b1;
      end else begin
         chain_reg <= taps[STAGES-1:0];
         prev_reg  <= chain_reg[STAGES-1];
      end
   end

   assign q    = chain_reg[STAGES-1];
   assign fall = prev_reg & ~q;
   assign rise = ~prev_reg & q;
endmodule

// File: rtl/j11pins.sv
// DCJ11 pin-side initiator: decodes each J11 bus cycle into a single-cycle
// internal request, returns the response on DAL and releases the CPU via CONT.
module j11pins
   import j11pins_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [21:0] j11dal_i,
   output logic [15:0] j11dal_o,
   output logic        j11dal_oe,
   input  logic [3:0]  j11aio,
   input  logic        j11ale_n,
   input  logic        j11sctl_n,
   input  logic        j11bufctl_n,
   output logic        j11cont_n,
   output logic        j11abort_n,
   j11pins_if.master   bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic ale_q, ale_fall, ale_rise;
   logic sctl_q, sctl_fall, sctl_rise;
   logic bufctl_q, bufctl_fall, bufctl_rise;

   j11sync #(.STAGES(SYNC_STAGES)) u_ale (
      .clk(clk), .rstn(rstn), .d(j11ale_n),
      .q(ale_q), .fall(ale_fall), .rise(ale_rise)
   );
   j11sync #(.STAGES(SYNC_STAGES)) u_sctl (
      .clk(clk), .rstn(rstn), .d(j11sctl_n),
      .q(sctl_q), .fall(sctl_fall), .rise(sctl_rise)
   );
   j11sync #(.STAGES(SYNC_STAGES)) u_bufctl (
      .clk(clk), .rstn(rstn), .d(j11bufctl_n),
      .q(bufctl_q), .fall(bufctl_fall), .rise(bufctl_rise)
   );

   logic unused_sync;
   assign unused_sync = ^{ale_q, ale_rise, sctl_q, bufctl_fall, bufctl_rise};

   state_t            state_reg, state_next;
   cls_t              cls_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              busreq_reg, buswr_reg, busgp_reg, busirq_reg;
   logic [21:0]       busaddr_reg;
   logic [15:0]       buswdata_reg, dal_o_reg;
   logic [1:0]        buswstrb_reg;
   logic              cont_n_reg, abort_n_reg;
   logic              timeout_hit;
   cls_t              ale_cls;

   assign ale_cls     = decode_aio(j11aio);
   // Fires on the cycle whose increment would make the counter equal TIMEOUT.
   assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (ale_fall && ale_cls != NONBUS) state_next = ADDR;
         ADDR: if (sctl_fall) state_next = WAIT;
         WAIT: begin
            if (bus.busack)       state_next = DONE;
            else if (sctl_rise)   state_next = IDLE;
            else if (timeout_hit) state_next = DONE;
         end
         DONE: if (sctl_rise) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cls_reg      <= NONBUS;
         cnt_reg      <= '0;
         busreq_reg   <= 1'b0;
         buswr_reg    <= 1'b0;
         busgp_reg    <= 1'b0;
         busirq_reg   <= 1'b0;
         busaddr_reg  <= '0;
         buswdata_reg <= '0;
         buswstrb_reg <= '0;
         dal_o_reg    <= '0;
         cont_n_reg   <= 1'b1;
         abort_n_reg  <= 1'b1;
      end else begin
         busreq_reg <= 1'b0;
         case (state_reg)
            IDLE: if (ale_fall) begin
               busaddr_reg  <= j11dal_i;
               cls_reg      <= ale_cls;
               buswstrb_reg <= wstrb_for(ale_cls, j11dal_i[0]);
            end
            ADDR: if (sctl_fall) begin
               busreq_reg <= 1'b1;
               if (is_write(cls_reg)) buswdata_reg <= j11dal_i[15:0];
               buswr_reg  <= is_write(cls_reg);
               busgp_reg  <= (cls_reg == GPREAD) || (cls_reg == GPWRITE);
               busirq_reg <= (cls_reg == IACK);
               cnt_reg    <= '0;
            end
            WAIT: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (bus.busack) begin
                  dal_o_reg   <= bus.busrdata;
                  cont_n_reg  <= 1'b0;
                  abort_n_reg <= ~bus.buserr;
               end else if (sctl_rise) begin
                  cnt_reg <= '0;
               end else if (timeout_hit) begin
                  dal_o_reg   <= 16'hffff;
                  cont_n_reg  <= 1'b0;
                  abort_n_reg <= 1'b0;
               end
            end
            DONE: if (sctl_rise) begin
               cont_n_reg  <= 1'b1;
               abort_n_reg <= 1'b1;
               cnt_reg     <= '0;
            end
            default: ;
         endcase
      end
   end

   assign j11dal_oe    = (state_reg == DONE) && is_read(cls_reg) && !bufctl_q;
   assign j11dal_o     = dal_o_reg;
   assign j11cont_n    = cont_n_reg;
   assign j11abort_n   = abort_n_reg;
   assign bus.busreq   = busreq_reg;
   assign bus.buswr    = buswr_reg;
   assign bus.busgp    = busgp_reg;
   assign bus.busirq   = busirq_reg;
   assign bus.busaddr  = busaddr_reg;
   assign bus.buswdata = buswdata_reg;
   assign bus.buswstrb = buswstrb_reg;
endmodule
